// File: rtl/mips_dbus_pkg.sv
// Shared constants for the MIPS data-bus responder: I/O register offsets,
// timer CTRL bit positions, reset constants and the decode target type.
package mips_dbus_pkg;

    localparam logic [15:0] OFF_CTRL     = 16'h0000;
    localparam logic [15:0] OFF_COUNT    = 16'h0004;
    localparam logic [15:0] OFF_CMP      = 16'h0008;
    localparam logic [15:0] OFF_STATUS   = 16'h000C;
    localparam logic [15:0] OFF_LED      = 16'h0010;
    localparam logic [15:0] OFF_SW       = 16'h0014;
    localparam logic [15:0] OFF_PRESCALE = 16'h0018;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AUTO  = 1;
    localparam int unsigned CTRL_IRQEN = 2;

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_RAM  = 2'd1,
        TGT_IO   = 2'd2
    } dbus_tgt_e;

endpackage

// File: rtl/dbus_timer.sv
// Memory-mapped timer: CTRL/COUNT/CMP/STATUS registers, match flag and level IRQ.
// Optional prescaler (PRESCALE register at 0x18) when TIMER_PRESCALE_EN is defined.
module dbus_timer
    import mips_dbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_ctrl,
    input  logic        we_count,
    input  logic        we_cmp,
    input  logic        we_status,
    input  logic        we_prescale,
    input  logic [31:0] wdata,
    input  logic [15:0] rd_off,
    output logic [31:0] rdata,
    output logic        timer_irq
);

    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        flag;
    logic        fire;
    logic        match;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale;
    logic [7:0] tick;

    assign fire = ctrl[CTRL_EN] && (tick == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            tick     <= '0;
        end else begin
            if (we_prescale)
                prescale <= wdata[7:0];
            if (we_ctrl || we_prescale)
                tick <= '0;
            else if (ctrl[CTRL_EN])
                tick <= fire ? '0 : tick + 8'd1;
        end
    end
`else
    logic unused_we_prescale;
    assign unused_we_prescale = we_prescale;
    assign fire = ctrl[CTRL_EN];
`endif

    assign match = fire && (count == cmp);

    // COUNT write beats increment/reload; a match beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= '0;
            count <= '0;
            cmp   <= CMP_RST;
            flag  <= 1'b0;
        end else begin
            if (we_ctrl)
                ctrl <= wdata[2:0];
            if (we_cmp)
                cmp <= wdata;
            if (we_count)
                count <= wdata;
            else if (fire)
                count <= (match && ctrl[CTRL_AUTO]) ? '0 : count + 32'd1;
            if (match)
                flag <= 1'b1;
            else if (we_status && wdata[0])
                flag <= 1'b0;
        end
    end

    assign timer_irq = flag & ctrl[CTRL_IRQEN];

    always_comb begin
        rdata = '0;
        case (rd_off)
            OFF_CTRL:     rdata = {29'd0, ctrl};
            OFF_COUNT:    rdata = count;
            OFF_CMP:      rdata = cmp;
            OFF_STATUS:   rdata = {31'd0, flag};
`ifdef TIMER_PRESCALE_EN
            OFF_PRESCALE: rdata = {24'd0, prescale};
`endif
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_dbus_responder.sv
// MEM-stage data-bus responder: word RAM, timer and LED/switch I/O with a
// combinational read path. Define TIMER_PRESCALE_EN to add the timer prescaler.
module mips_dbus_responder
    import mips_dbus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  led_q;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    dbus_tgt_e   tgt;
    logic [15:0] io_off;
    logic [AW-1:0] ram_idx;
    logic        io_we;
    logic [31:0] timer_rdata;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, memaddr[1:0]};
    assign io_off  = {memaddr[15:2], 2'b00};
    assign ram_idx = memaddr[AW+1:2];

    always_comb begin
        tgt = TGT_NONE;
        if (memaddr[31:16] == IO_BASE[31:16])
            tgt = TGT_IO;
        else if ({2'b00, memaddr[31:2]} < 32'(RAM_WORDS))
            tgt = TGT_RAM;
    end

    assign io_we = memwrite && (tgt == TGT_IO);

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (memwrite && (tgt == TGT_RAM))
            ram[ram_idx] <= memwritedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (io_we && (io_off == OFF_LED))
                led_q <= memwritedata[7:0];
        end
    end

    assign leds = led_q;

    dbus_timer u_timer (
        .clk         (clk),
        .rst_n       (reset),
        .we_ctrl     (io_we && (io_off == OFF_CTRL)),
        .we_count    (io_we && (io_off == OFF_COUNT)),
        .we_cmp      (io_we && (io_off == OFF_CMP)),
        .we_status   (io_we && (io_off == OFF_STATUS)),
        .we_prescale (io_we && (io_off == OFF_PRESCALE)),
        .wdata       (memwritedata),
        .rd_off      (io_off),
        .rdata       (timer_rdata),
        .timer_irq   (timer_irq)
    );

    always_comb begin
        memreaddata = '0;
        case (tgt)
            TGT_RAM: memreaddata = ram[ram_idx];
            TGT_IO: begin
                case (io_off)
                    OFF_LED: memreaddata = {24'd0, led_q};
                    OFF_SW:  memreaddata = {24'd0, sw_sync};
                    default: memreaddata = timer_rdata;
                endcase
            end
            default: memreaddata = '0;
        endcase
    end

endmodule
